// File: rtl/bus_ctl_pkg.sv
// Shared definitions for the 8-bit bus control sequencer.
//   - device codes placed on the assert/load control words
//   - instruction opcodes and the sequencer state encoding
//   - default control-word widths
//   - reg_code(): maps a 2-bit register field (A..D) to its device code
package bus_ctl_pkg;

   localparam int DEV_W_DEF  = 5;
   localparam int WIDE_W_DEF = 4;

   // Device codes on the 8-bit bus control words.
   localparam int unsigned DEV_NONE  = 0;
   localparam int unsigned DEV_CONST = 1;
   localparam int unsigned DEV_A     = 2;
   localparam int unsigned DEV_B     = 3;
   localparam int unsigned DEV_C     = 4;
   localparam int unsigned DEV_D     = 5;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_MOV = 2'b01,
      OP_LDI = 2'b10,
      OP_HLT = 2'b11
   } opcode_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXEC   = 3'd1,
      ST_LDI1   = 3'd2,
      ST_LDI2   = 3'd3,
      ST_HALTED = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   // Register fields 0..3 select A..D, whose codes follow A contiguously.
   function automatic logic [2:0] reg_code(input logic [1:0] field);
      return 3'(field) + 3'(DEV_A);
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   instr    in   8      [7:6] opcode, [5:3] dst field, [2:0] src field
//   opcode   out  2      decoded opcode
//   dst_code out  DEV_W  device code for the dst register field
//   src_code out  DEV_W  device code for the src register field
//   illegal  out  1      a field the opcode actually uses is outside A..D
module instr_decoder
   import bus_ctl_pkg::*;
#(
   parameter int DEV_W = DEV_W_DEF
) (
   input  logic [7:0]       instr,
   output opcode_t          opcode,
   output logic [DEV_W-1:0] dst_code,
   output logic [DEV_W-1:0] src_code,
   output logic             illegal
);

   // NOTE: every output gets a default before the case so no path leaves
   // a value unassigned, which would otherwise infer a latch.
   always_comb begin
      opcode   = opcode_t'(instr[7:6]);
      dst_code = DEV_W'(reg_code(instr[4:3]));
      src_code = DEV_W'(reg_code(instr[1:0]));
      illegal  = 1'b0;
      // Field bit 2 set means register 4..7, which does not exist. Only
      // fields the opcode reads are policed; LDI ignores its src field.
      case (opcode)
         OP_MOV:  illegal = instr[5] | instr[2];
         OP_LDI:  illegal = instr[5];
         default: illegal = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer for an 8-bit register bus.
// Accepts one instruction per valid/ready handshake and issues registered
// assert/load control words selecting which device drives and which loads
// the 8-bit bus.
// Ports:
//   clk                  in   1       rising-edge clock
//   rst                  in   1       asynchronous active-high reset
//   i_instr              in   8       [7:6] opcode, [5:3] dst, [2:0] src
//   i_imm                in   8       immediate byte for LDI
//   i_instr_valid        in   1       instruction word available
//   o_instr_ready        out  1       sequencer is idle and can accept
//   o_8bit_assert_word   out  DEV_W   device driving the 8-bit bus
//   o_8bit_load_word     out  DEV_W   device loading from the 8-bit bus
//   o_16bit_assert_word  out  WIDE_W  reserved, always 0
//   o_16bit_load_word    out  WIDE_W  reserved, always 0
//   o_bus_in             out  8       immediate for the constant register
//   o_instr_count        out  8       retired instruction count (wraps)
//   o_halted             out  1       HLT executed
//   o_error              out  1       illegal register field seen
module control_sequencer
   import bus_ctl_pkg::*;
#(
   parameter int DEV_W  = DEV_W_DEF,
   parameter int WIDE_W = WIDE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        i_instr,
   input  logic [7:0]        i_imm,
   input  logic              i_instr_valid,
   output logic              o_instr_ready,
   output logic [DEV_W-1:0]  o_8bit_assert_word,
   output logic [DEV_W-1:0]  o_8bit_load_word,
   output logic [WIDE_W-1:0] o_16bit_assert_word,
   output logic [WIDE_W-1:0] o_16bit_load_word,
   output logic [7:0]        o_bus_in,
   output logic [7:0]        o_instr_count,
   output logic              o_halted,
   output logic              o_error
);

   state_t           state, next_state;
   opcode_t          dec_opcode;
   logic [DEV_W-1:0] dec_dst, dec_src;
   logic             dec_illegal;
   logic             accept;

   logic [DEV_W-1:0] dst_q;
   logic [DEV_W-1:0] assert_d, load_d;
   logic [DEV_W-1:0] assert_q, load_q;
   logic [7:0]       bus_in_d, bus_in_q;
   logic [7:0]       count_q;

   instr_decoder #(.DEV_W(DEV_W)) u_decoder (
      .instr    (i_instr),
      .opcode   (dec_opcode),
      .dst_code (dec_dst),
      .src_code (dec_src),
      .illegal  (dec_illegal)
   );

   // Gated by rst so the source never sees ready while reset is held.
   assign o_instr_ready = (state == ST_IDLE) && !rst;
   assign accept        = i_instr_valid && o_instr_ready;

   // ---------------- state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (dec_illegal) begin
                  next_state = ST_ERROR;
               end else begin
                  case (dec_opcode)
                     OP_NOP, OP_MOV: next_state = ST_EXEC;
                     OP_LDI:         next_state = ST_LDI1;
                     OP_HLT:         next_state = ST_HALTED;
                     default:        next_state = ST_IDLE;
                  endcase
               end
            end
         end
         ST_EXEC:   next_state = ST_IDLE;
         ST_LDI1:   next_state = ST_LDI2;
         ST_LDI2:   next_state = ST_IDLE;
         ST_HALTED: next_state = ST_HALTED;
         ST_ERROR:  next_state = ST_ERROR;
         default:   next_state = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // Computes the words for the state being entered; the output register
   // below makes them appear in that state as clean Moore outputs.
   always_comb begin
      assert_d = DEV_W'(DEV_NONE);
      load_d   = DEV_W'(DEV_NONE);
      bus_in_d = bus_in_q;
      case (state)
         ST_IDLE: begin
            if (accept && !dec_illegal) begin
               case (dec_opcode)
                  OP_MOV: begin
                     assert_d = dec_src;
                     load_d   = dec_dst;
                  end
                  OP_LDI: begin
                     load_d   = DEV_W'(DEV_CONST);
                     bus_in_d = i_imm;
                  end
                  default: ;
               endcase
            end
         end
         // Entering LDI2: constant register drives, captured dst loads.
         ST_LDI1: begin
            assert_d = DEV_W'(DEV_CONST);
            load_d   = dst_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         assert_q <= '0;
         load_q   <= '0;
         bus_in_q <= '0;
         dst_q    <= '0;
         count_q  <= '0;
      end else begin
         assert_q <= assert_d;
         load_q   <= load_d;
         bus_in_q <= bus_in_d;
         if (accept) dst_q <= dec_dst;
         // EXEC and LDI2 are the final execute cycles; 8-bit add wraps.
         if (state == ST_EXEC || state == ST_LDI2) count_q <= count_q + 8'd1;
      end
   end

   assign o_8bit_assert_word  = assert_q;
   assign o_8bit_load_word    = load_q;
   assign o_16bit_assert_word = '0;
   assign o_16bit_load_word   = '0;
   assign o_bus_in            = bus_in_q;
   assign o_instr_count       = count_q;
   assign o_halted            = (state == ST_HALTED);
   assign o_error             = (state == ST_ERROR);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] i_instr = 8'h00;
   logic [7:0] i_imm = 8'h00;
   logic       i_instr_valid = 1'b0;
   logic       o_instr_ready;
   logic [4:0] o_8bit_assert_word, o_8bit_load_word;
   logic [3:0] o_16bit_assert_word, o_16bit_load_word;
   logic [7:0] o_bus_in, o_instr_count;
   logic       o_halted, o_error;

   int n_vec = 0;
   int n_bad = 0;

   control_sequencer dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_instr             (i_instr),
      .i_imm               (i_imm),
      .i_instr_valid       (i_instr_valid),
      .o_instr_ready       (o_instr_ready),
      .o_8bit_assert_word  (o_8bit_assert_word),
      .o_8bit_load_word    (o_8bit_load_word),
      .o_16bit_assert_word (o_16bit_assert_word),
      .o_16bit_load_word   (o_16bit_load_word),
      .o_bus_in            (o_bus_in),
      .o_instr_count       (o_instr_count),
      .o_halted            (o_halted),
      .o_error             (o_error)
   );

   always #5 clk = ~clk;

   // Packed view {ready, halted, error, assert, load, bus_in, count}.
   function automatic logic [28:0] exp_o(input logic r, input logic h, input logic e,
                                         input logic [4:0] a, input logic [4:0] l,
                                         input logic [7:0] b, input logic [7:0] c);
      return {r, h, e, a, l, b, c};
   endfunction

   function automatic logic [28:0] cur_o();
      return {o_instr_ready, o_halted, o_error, o_8bit_assert_word,
              o_8bit_load_word, o_bus_in, o_instr_count};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (r,h,e,asrt,load,bus,cnt packed)", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [28:0] exp);
      check(name, {3'b000, cur_o()}, {3'b000, exp});
      check({name, "_w16"}, {24'h0, o_16bit_assert_word, o_16bit_load_word}, 32'h0);
   endtask

   // Drive inputs just after an edge, advance one clock, settle past it.
   task automatic step(input logic v, input logic [7:0] ins, input logic [7:0] imm);
      i_instr_valid = v;
      i_instr       = ins;
      i_imm         = imm;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_instr_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_outs("reset_async", exp_o(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'h00));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        valid;
      logic [7:0]  instr;
      logic [7:0]  imm;
      logic [28:0] exp;
   } vec_t;

   vec_t vecs[18];

   initial begin
      // Main sequence from reset: MOV, LDI, MOV/LDI alternation, NOP.
      vecs[0]  = '{1'b0, 8'h00, 8'h00, exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'd0)};
      vecs[1]  = '{1'b1, 8'h4B, 8'h00, exp_o(1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 8'h00, 8'd0)};
      vecs[2]  = '{1'b0, 8'h00, 8'h00, exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'd1)};
      vecs[3]  = '{1'b1, 8'h90, 8'hA5, exp_o(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 8'hA5, 8'd1)};
      vecs[4]  = '{1'b1, 8'h4B, 8'h00, exp_o(1'b0, 1'b0, 1'b0, 5'd1, 5'd4, 8'hA5, 8'd1)};
      vecs[5]  = '{1'b1, 8'h4B, 8'h00, exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'hA5, 8'd2)};
      vecs[6]  = '{1'b1, 8'h4B, 8'h00, exp_o(1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 8'hA5, 8'd2)};
      vecs[7]  = '{1'b1, 8'h52, 8'h00, exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'hA5, 8'd3)};
      vecs[8]  = '{1'b1, 8'h52, 8'h00, exp_o(1'b0, 1'b0, 1'b0, 5'd4, 5'd4, 8'hA5, 8'd3)};
      vecs[9]  = '{1'b1, 8'h88, 8'h3C, exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'hA5, 8'd4)};
      vecs[10] = '{1'b1, 8'h88, 8'h3C, exp_o(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 8'h3C, 8'd4)};
      vecs[11] = '{1'b0, 8'h00, 8'h00, exp_o(1'b0, 1'b0, 1'b0, 5'd1, 5'd3, 8'h3C, 8'd4)};
      vecs[12] = '{1'b0, 8'h00, 8'h00, exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h3C, 8'd5)};
      vecs[13] = '{1'b1, 8'h00, 8'h00, exp_o(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h3C, 8'd5)};
      vecs[14] = '{1'b0, 8'h00, 8'h00, exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h3C, 8'd6)};
      vecs[15] = '{1'b1, 8'h9F, 8'h11, exp_o(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 8'h11, 8'd6)};
      vecs[16] = '{1'b0, 8'h00, 8'h00, exp_o(1'b0, 1'b0, 1'b0, 5'd1, 5'd5, 8'h11, 8'd6)};
      vecs[17] = '{1'b0, 8'h00, 8'h00, exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h11, 8'd7)};

      #1;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         step(vecs[i].valid, vecs[i].instr, vecs[i].imm);
         check_outs($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Illegal MOV dst: sticky error, no words, count frozen.
      step(1'b1, 8'h64, 8'h00);
      check_outs("illegal_dst", exp_o(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 8'h11, 8'd7));
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h4B, 8'h00);
         check_outs($sformatf("error_hold%0d", i), exp_o(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 8'h11, 8'd7));
      end
      do_reset();
      // Illegal MOV src with a legal dst.
      step(1'b1, 8'h4C, 8'h00);
      check_outs("illegal_src", exp_o(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 8'h00, 8'd0));
      do_reset();

      // HLT: halted and deaf to valid until reset.
      step(1'b1, 8'hC0, 8'h00);
      check_outs("halt", exp_o(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 8'h00, 8'd0));
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'h4B, 8'h00);
         check_outs($sformatf("halt_hold%0d", i), exp_o(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 8'h00, 8'd0));
      end
      do_reset();

      // 256 back-to-back NOPs, 2 cycles each: count passes 255 and wraps.
      for (int i = 0; i < 510; i++) step(1'b1, 8'h00, 8'h00);
      check_outs("nop255", exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'd255));
      step(1'b1, 8'h00, 8'h00);
      check_outs("nop256_exec", exp_o(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'd255));
      step(1'b0, 8'h00, 8'h00);
      check_outs("nop_wrap", exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'd0));

      // Reset during LDI1: outputs clear at once and LDI2 never appears.
      step(1'b1, 8'h90, 8'hA5);
      check_outs("ldi1_pre_rst", exp_o(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 8'hA5, 8'd0));
      i_instr_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_outs("rst_in_ldi1", exp_o(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'd0));
      @(posedge clk);
      #1;
      check_outs("rst_held", exp_o(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'd0));
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 8'h00, 8'h00);
      check_outs("post_rst_no_ldi2", exp_o(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'd0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have the parameter DEV_W, default 5, giving the width of the 8-bit-bus assert/load control words.
REQ-002 SHALL have the parameter WIDE_W, default 4, giving the width of the 16-bit-bus assert/load control words.
REQ-003 SHALL have the port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have the port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have the port i_instr  input  8  instruction: [7:6] opcode, [5:3] dst field, [2:0] src field.
REQ-006 SHALL have the port i_imm  input  8  immediate byte, sampled together with i_instr.
REQ-007 SHALL have the port i_instr_valid  input  1  instruction source has a word on i_instr/i_imm.
REQ-008 SHALL have the port o_instr_ready  output  1  sequencer can accept an instruction this cycle.
REQ-009 SHALL have the port o_8bit_assert_word  output  DEV_W  device driving b_8bit_main (0 = none).
REQ-010 SHALL have the port o_8bit_load_word  output  DEV_W  device loading from b_8bit_main (0 = none).
REQ-011 SHALL have the port o_16bit_assert_word  output  WIDE_W  16-bit bus assert word; reserved.
REQ-012 SHALL have the port o_16bit_load_word  output  WIDE_W  16-bit bus load word; reserved.
REQ-013 SHALL have the port o_bus_in  output  8  immediate presented to the constant register input.
REQ-014 SHALL have the port o_instr_count  output  8  count of retired instructions.
REQ-015 SHALL have the port o_halted  output  1  HLT executed.
REQ-016 SHALL have the port o_error  output  1  illegal register field seen.

Function
REQ-017 SHALL use these device codes: 0 none, 1 constant, 2 A, 3 B, 4 C, 5 D; register field values 0..3 map to A..D (code = field+2), and values 4..7 are illegal.
REQ-018 SHALL decode opcodes as 00 NOP, 01 MOV dst,src, 10 LDI dst (src ignored), 11 HLT.
REQ-019 SHALL implement the states IDLE, EXEC, LDI1, LDI2, HALTED and ERROR.
REQ-020 SHALL drive o_instr_ready high exactly when the state is IDLE.
REQ-021 SHALL accept a handshake only when i_instr_valid and o_instr_ready are both high, capturing i_instr and i_imm on that edge; when valid is low, IDLE SHALL hold with all words 0.
REQ-022 SHALL register all control words and o_bus_in (Moore outputs), with the first word of an instruction appearing in the cycle after acceptance and each word stable for one full cycle.
REQ-023 SHALL execute NOP as IDLE -> EXEC (one cycle, all words 0) -> IDLE.
REQ-024 SHALL execute MOV as IDLE -> EXEC (one cycle: assert = src code, load = dst code) -> IDLE.
REQ-025 SHALL treat MOV with src == dst as legal and issue it normally.
REQ-026 SHALL execute LDI as IDLE -> LDI1 (assert 0, load 1, o_bus_in = imm) -> LDI2 (assert 1, load = dst code) -> IDLE.
REQ-027 SHALL hold o_bus_in at its last value outside LDI1.
REQ-028 SHALL execute HLT as IDLE -> HALTED, with all words 0, o_halted = 1 and ready = 0, held until reset.
REQ-029 SHALL send an instruction with an illegal field it uses (MOV src or dst, LDI dst) IDLE -> ERROR with no words issued, o_error = 1, and ready = 0, sticky until reset.
REQ-030 SHALL increment o_instr_count by 1 on the last execute cycle of NOP, MOV and LDI, and not for HLT or illegal instructions.
REQ-031 SHALL wrap o_instr_count from 255 to 0.
REQ-032 SHALL hold both 16-bit words at 0 in all states.
REQ-033 SHALL never make the assert and load words equal and nonzero, except for MOV with src == dst.
REQ-034 SHALL allow a back-to-back instruction to be accepted in the first IDLE cycle after completion, giving a throughput of one MOV every 2 cycles and one LDI every 3 cycles.

Reset
REQ-035 SHALL asynchronously force the state to IDLE while rst is high.
REQ-036 SHALL asynchronously clear all words, o_bus_in, o_instr_count, o_halted and o_error to 0 while rst is high.
REQ-037 SHALL hold o_instr_ready at 0 while rst is high.
REQ-038 SHALL abandon any instruction in progress on reset (for example LDI1 followed by rst gives no LDI2).
REQ-039 SHALL raise o_instr_ready in the first cycle after rst falls.

Structure
REQ-040 SHALL place the device codes, opcode values, state encoding and DEV_W/WIDE_W defaults in a shared package, bus_ctl_pkg.
REQ-041 SHALL use one combinational sub-module, instr_decoder, mapping the 8-bit instruction to opcode, dst code, src code and an illegal flag.

Verification
REQ-042 SHALL be verified with MOV: i_instr = 0x4B (dst 1 = B, src 3 = D), valid for 1 cycle, must give next cycle assert = 5 and load = 3, then IDLE with count = 1.
REQ-043 SHALL be verified with LDI: i_instr = 0x90 (dst 2 = C) and i_imm = 0xA5, which must give LDI1 (assert 0, load 1, bus_in 0xA5) then LDI2 (assert 1, load 4), with ready low for 2 cycles.
REQ-044 SHALL be verified with an illegal field: i_instr = 0x64 (MOV dst 4), which must give o_error = 1, no nonzero words, ready low, and count unchanged until rst.
REQ-045 SHALL be verified with HLT: i_instr = 0xC0, which must give o_halted = 1, valid then ignored for 10 cycles, and rst clearing it.
REQ-046 SHALL be verified with wrap-around: 256 NOPs back-to-back must return o_instr_count to 0, and MOV/LDI alternation must show correct 2- and 3-cycle spacing.
REQ-047 SHALL be verified with reset during LDI1, which must clear all outputs immediately, produce no LDI2 load word, and raise ready one cycle after release.
